// File: rtl/video_pkg.sv
// Shared video timing constants and scanout types.
// Default is 640x480@60 with a 320x240 pixel-doubled alias.
package video_pkg;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_CW     = 4;
    localparam int DEF_AW     = 19;

    // Framebuffer geometry seen by software in doubled mode
    localparam int LR_H_VIS   = DEF_H_VIS / 2;
    localparam int LR_V_VIS   = DEF_V_VIS / 2;

    typedef enum logic {
        MODE_NATIVE = 1'b0,
        MODE_DOUBLE = 1'b1
    } scan_mode_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic frame;
    } sync_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Raster position and sync bundle from the timing generator.
// Signals are combinational in the counter state.
interface vga_scanout_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          visible;
    logic          hs;
    logic          vs;
    logic          frame_start;

    modport master (
        output x, y, visible, hs, vs, frame_start
    );

    modport slave (
        input  x, y, visible, hs, vs, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Raster counters and sync decode for the scanout.
// All outputs are decoded from the current counter state.
module vga_timing
    import video_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET_N,
    vga_scanout_if.master tim
);

    localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int          XW     = $clog2(H_TOT);
    localparam int          YW     = $clog2(V_TOT);
    localparam int unsigned HS_BEG = H_VIS + H_FP;
    localparam int unsigned HS_END = H_VIS + H_FP + H_SYNC;
    localparam int unsigned VS_BEG = V_VIS + V_FP;
    localparam int unsigned VS_END = V_VIS + V_FP + V_SYNC;
    localparam int unsigned H_V    = H_VIS;
    localparam int unsigned V_V    = V_VIS;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_wrap;
    logic          w_y_wrap;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_x_wrap = (r_x == X_LAST);
    assign w_y_wrap = (r_y == Y_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_wrap ? '0 : r_x + XW'(1);
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? '0 : r_y + YW'(1);
            end
        end
    end

    assign w_hs_act = (32'(r_x) >= HS_BEG) && (32'(r_x) < HS_END);
    assign w_vs_act = (32'(r_y) >= VS_BEG) && (32'(r_y) < VS_END);

    assign tim.x           = r_x;
    assign tim.y           = r_y;
    assign tim.visible     = (32'(r_x) < H_V) && (32'(r_y) < V_V);
    assign tim.hs          = w_hs_act ? HS_POL : ~HS_POL;
    assign tim.vs          = w_vs_act ? VS_POL : ~VS_POL;
    assign tim.frame_start = (r_x == '0) && (r_y == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: timing, incremental framebuffer addressing and
// a two-stage pipeline aligning sync with returned pixel data.
module vga_scanout
    import video_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CW     = DEF_CW,
    parameter int AW     = DEF_AW
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          MODE,
    output logic [AW-1:0] ADDR,
    input  logic [3*CW-1:0] DATA,
    output logic [CW-1:0] R,
    output logic [CW-1:0] G,
    output logic [CW-1:0] B,
    output logic          HS,
    output logic          VS,
    output logic          DE,
    output logic          FRAME
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOT - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOT - 1);
    localparam logic [XW-1:0] X_VLAST  = XW'(H_VIS - 1);
    localparam logic [AW-1:0] STRIDE_N = AW'(H_VIS);
    localparam logic [AW-1:0] STRIDE_D = AW'(H_VIS / 2);

    localparam sync_t SYNC_IDLE = '{
        hs:    ~HS_POL,
        vs:    ~VS_POL,
        de:    1'b0,
        frame: 1'b0
    };

    vga_scanout_if #(.XW(XW), .YW(YW)) w_tim ();

    vga_timing #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) u_timing (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .tim     (w_tim)
    );

    scan_mode_e    r_mode;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_addr;
    sync_t         r_s1;
    sync_t         r_s2;

    logic [AW-1:0] w_col;
    logic [AW-1:0] w_stride;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_base_step;
    sync_t         w_s0;

    // Doubled mode steps the base only after the odd line of each pair
    always_comb begin
        w_col       = AW'(w_tim.x);
        w_stride    = STRIDE_N;
        w_base_step = 1'b0;
        w_line_end  = w_tim.visible && (w_tim.x == X_VLAST);
        w_frame_end = (w_tim.x == X_LAST) && (w_tim.y == Y_LAST);
        if (r_mode == MODE_DOUBLE) begin
            w_col       = AW'(w_tim.x >> 1);
            w_stride    = STRIDE_D;
            w_base_step = w_line_end && w_tim.y[0];
        end else begin
            w_base_step = w_line_end;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mode <= MODE_NATIVE;
            r_base <= '0;
            r_addr <= '0;
        end else begin
            if (w_tim.frame_start) begin
                r_mode <= scan_mode_e'(MODE);
            end
            if (w_frame_end) begin
                r_base <= '0;
            end else if (w_base_step) begin
                r_base <= r_base + w_stride;
            end
            if (w_tim.visible) begin
                r_addr <= r_base + w_col;
            end
        end
    end

    assign w_s0 = '{
        hs:    w_tim.hs,
        vs:    w_tim.vs,
        de:    w_tim.visible,
        frame: w_tim.frame_start
    };

    // Two stages match the one-clock framebuffer read after ADDR
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1 <= SYNC_IDLE;
            r_s2 <= SYNC_IDLE;
        end else begin
            r_s1 <= w_s0;
            r_s2 <= r_s1;
        end
    end

    assign ADDR  = r_addr;
    assign HS    = r_s2.hs;
    assign VS    = r_s2.vs;
    assign DE    = r_s2.de;
    assign FRAME = r_s2.frame;
    assign R     = r_s2.de ? DATA[3*CW-1:2*CW] : '0;
    assign G     = r_s2.de ? DATA[2*CW-1:CW]   : '0;
    assign B     = r_s2.de ? DATA[CW-1:0]      : '0;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster.
// Reference derives position and address from the cycle count.
module tb_vga_scanout;

    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HB  = 3;
    localparam int VV  = 8;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 2;
    localparam bit HP  = 1'b0;
    localparam bit VP  = 1'b1;
    localparam int CW  = 4;
    localparam int AW  = 8;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;
    localparam int FR  = HT * VT;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          MODE = 1'b0;
    logic [AW-1:0] ADDR;
    logic [11:0]   DATA = 12'h0;
    logic [CW-1:0] R;
    logic [CW-1:0] G;
    logic [CW-1:0] B;
    logic          HS;
    logic          VS;
    logic          DE;
    logic          FRAME;

    vga_scanout #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .CW(CW), .AW(AW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MODE(MODE),
        .ADDR(ADDR), .DATA(DATA),
        .R(R), .G(G), .B(B),
        .HS(HS), .VS(VS), .DE(DE), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    logic [11:0] mem [2**AW];
    logic        all_ones = 1'b0;

    always @(posedge CLK) DATA <= all_ones ? 12'hFFF : mem[ADDR];

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fr;
        logic [11:0] rgb;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            k = 0;
    int            fmode = 0;
    int            last_a = 0;

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s k=%0d got %0h exp %0h", nm, k, got, want);
        end
    endtask

    task automatic push_state();
        int   x, y, a;
        bit   vis;
        exp_t e;
        x = k % HT;
        y = (k / HT) % VT;
        if (x == 0 && y == 0) fmode = int'(MODE);
        vis = (x < HV) && (y < VV);
        if (vis) begin
            if (fmode != 0) a = (y / 2) * (HV / 2) + x / 2;
            else            a = y * HV + x;
            last_a = a;
        end
        e.de  = vis;
        e.hs  = (x >= HV + HF && x < HV + HF + HSY) ? HP : !HP;
        e.vs  = (y >= VV + VF && y < VV + VF + VSY) ? VP : !VP;
        e.fr  = (x == 0 && y == 0);
        e.rgb = !vis ? 12'h0 : (all_ones ? 12'hFFF : mem[last_a]);
        exp_q.push_back(e);
        addr_q.push_back(AW'(last_a));
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_addr"}, int'(ADDR), 0);
        chk({tag, "_de"}, int'(DE), 0);
        chk({tag, "_frame"}, int'(FRAME), 0);
        chk({tag, "_hs"}, int'(HS), int'(!HP));
        chk({tag, "_vs"}, int'(VS), int'(!VP));
        chk({tag, "_rgb"}, int'({R, G, B}), 0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        k++;
    endtask

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (addr_q.size() >= 2) chk("addr", int'(ADDR), int'(addr_q.pop_front()));
            if (exp_q.size() >= 3) begin
                mon_e = exp_q.pop_front();
                chk("de", int'(DE), int'(mon_e.de));
                chk("hs", int'(HS), int'(mon_e.hs));
                chk("vs", int'(VS), int'(mon_e.vs));
                chk("frame", int'(FRAME), int'(mon_e.fr));
                chk("rgb", int'({R, G, B}), int'(mon_e.rgb));
            end
        end
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 12'($urandom);
        repeat (3) @(posedge CLK);
        #1;
        check_reset("init");

        k = 0;
        RESET_N = 1'b1;
        push_state();
        // Native frames, MODE raised mid-frame at line 4 of frame 1
        while (k < 3 * FR - 1) begin
            step();
            if (k == FR + 4 * HT) MODE = 1'b1;
            push_state();
        end
        // MODE toggles freely; only the frame-start sample matters
        while (k < 5 * FR + 4 * HT + 7) begin
            step();
            MODE = 1'($urandom_range(0, 1));
            push_state();
        end

        RESET_N = 1'b0;
        #1;
        check_reset("arst");
        exp_q.delete();
        addr_q.delete();
        all_ones = 1'b1;
        MODE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("hold");

        k = 0;
        last_a = 0;
        RESET_N = 1'b1;
        push_state();
        while (k < FR + FR / 2) begin
            step();
            push_state();
        end
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
